encdec_sequencer: RTL and testbench
===================================

ENCDEC_SEQUENCER -- requirements
Module: encdec_sequencer

Interface
REQ-001 SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-002 SHALL have parameter AMBA_WORD, default 32, APB data and register width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, datapath word width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles spent waiting for dp_done.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-008 SHALL have ports PADDR  input  AMBA_ADDR_WIDTH and PWDATA  input  AMBA_WORD  APB address and write data.
REQ-009 SHALL have ports PRDATA  output  AMBA_WORD, PREADY  output  1 and PSLVERR  output  1  APB response.
REQ-010 SHALL have ports dp_start  output  1, dp_mode  output  2, dp_width  output  2, dp_data_in  output  DATA_WIDTH and dp_noise  output  DATA_WIDTH  datapath command.
REQ-011 SHALL have ports dp_done  input  1, dp_data_out  input  DATA_WIDTH and dp_nof  input  2  datapath result.
REQ-012 SHALL have ports data_out  output  DATA_WIDTH, num_of_errors  output  2, operation_done  output  1, busy  output  1 and op_error  output  1  results to system.

Function
REQ-013 SHALL decode registers on PADDR[3:2]: 00 CTRL, 01 DATA_IN, 10 CODEWORD_WIDTH, 11 NOISE.
REQ-014 SHALL commit a write when PSEL&PENABLE&PWRITE; PREADY SHALL be constant 1 (zero wait states).
REQ-015 SHALL drive PRDATA combinationally with the selected register when PSEL&~PWRITE, else 0.
REQ-016 SHALL run FSM IDLE -> LOAD -> WAIT -> DONE -> IDLE; busy SHALL be 1 in every state except IDLE.
REQ-017 IDLE: a committed write to CTRL SHALL store PWDATA and move to LOAD next cycle; writes to other registers SHALL only store data.
REQ-018 LOAD (1 cycle): dp_start=1; dp_mode=CTRL[1:0]; dp_width=CODEWORD_WIDTH[1:0]; dp_data_in=DATA_IN; dp_noise=NOISE; all four dp_ command outputs SHALL hold these values through WAIT.
REQ-019 LOAD with CTRL[1:0]==11 SHALL NOT assert dp_start and SHALL go directly to DONE with op_error=1.
REQ-020 WAIT: 5-bit cycle counter cleared in LOAD, incremented each WAIT cycle; dp_done=1 SHALL move to DONE; counter reaching TIMEOUT-1 with dp_done=0 SHALL move to DONE with op_error=1.
REQ-021 dp_done and timeout in the same cycle SHALL be treated as success (op_error=0).
REQ-022 DONE (1 cycle): operation_done=1; on success latch data_out=dp_data_out and num_of_errors=dp_nof, except num_of_errors=00 when dp_mode==00 (encode); on error data_out=0, num_of_errors=00.
REQ-023 data_out, num_of_errors and op_error SHALL hold until the next LOAD, where op_error clears.
REQ-024 Any committed write while busy=1 SHALL be ignored (no register change) and SHALL assert PSLVERR in that access cycle; reads while busy SHALL be legal.
REQ-025 dp_done outside WAIT SHALL be ignored.
REQ-026 dp_width 11 SHALL be passed unchanged (datapath treats it as 32-bit).

Reset
REQ-027 rst=1 SHALL asynchronously force FSM to IDLE, clear all four registers, counter, and every output (PRDATA, PSLVERR, dp_*, data_out, num_of_errors, operation_done, busy, op_error) to 0; PREADY remains 1.
REQ-028 rst asserted mid-operation SHALL abandon the operation with no operation_done pulse after release.

Verification
REQ-029 Write DATA_IN=0x0000_00A5, CODEWORD_WIDTH=0, CTRL=0 -> dp_start 1 cycle after CTRL write, dp_done 3 cycles later with dp_data_out=0x5A -> operation_done pulse, data_out=0x5A, num_of_errors=00.
REQ-030 CTRL=1, NOISE=0x3, dp_done with dp_nof=10 -> num_of_errors=10, op_error=0.
REQ-031 CTRL=2, dp_done never asserted -> operation_done after LOAD+TIMEOUT cycles with op_error=1, data_out=0.
REQ-032 CTRL=3 -> no dp_start, operation_done 2 cycles after write, op_error=1.
REQ-033 Write DATA_IN=0x1234 during WAIT -> PSLVERR=1 that cycle, read-back of DATA_IN returns old value.
REQ-034 rst pulsed during WAIT -> busy=0, all registers read 0, no operation_done after release.

Source files
------------

// File: rtl/encdec_sequencer.sv
// APB-programmed sequencer for an encode/decode datapath: holds the command
// registers, launches one datapath operation per CTRL write and latches the result.
module encdec_sequencer #(
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       dp_start,
  output logic [1:0]                 dp_mode,
  output logic [1:0]                 dp_width,
  output logic [DATA_WIDTH-1:0]      dp_data_in,
  output logic [DATA_WIDTH-1:0]      dp_noise,
  input  logic                       dp_done,
  input  logic [DATA_WIDTH-1:0]      dp_data_out,
  input  logic [1:0]                 dp_nof,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy,
  output logic                       op_error
);

  localparam int unsigned CNT_W = 5;
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_DATA   = 2'b01;
  localparam logic [1:0] ADDR_WIDTH  = 2'b10;
  localparam logic [1:0] ADDR_NOISE  = 2'b11;
  localparam logic [1:0] MODE_ENC    = 2'b00;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [AMBA_WORD-1:0] r_ctrl;
  logic [AMBA_WORD-1:0] r_data_in;
  logic [AMBA_WORD-1:0] r_cw_width;
  logic [AMBA_WORD-1:0] r_noise;
  logic [CNT_W-1:0]     r_cnt;

  logic       w_wr;
  logic [1:0] w_sel;
  logic       w_unused_addr;

  assign w_wr          = PSEL & PENABLE & PWRITE;
  assign w_sel         = PADDR[3:2];
  assign w_unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
  assign PREADY        = 1'b1;
  assign PSLVERR       = w_wr & busy;

  // Read mux; registers stay readable while an operation runs
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_sel)
        ADDR_CTRL:  PRDATA = r_ctrl;
        ADDR_DATA:  PRDATA = r_data_in;
        ADDR_WIDTH: PRDATA = r_cw_width;
        ADDR_NOISE: PRDATA = r_noise;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ctrl         <= '0;
      r_data_in      <= '0;
      r_cw_width     <= '0;
      r_noise        <= '0;
      r_cnt          <= '0;
      dp_start       <= 1'b0;
      dp_mode        <= 2'b00;
      dp_width       <= 2'b00;
      dp_data_in     <= '0;
      dp_noise       <= '0;
      data_out       <= '0;
      num_of_errors  <= 2'b00;
      operation_done <= 1'b0;
      busy           <= 1'b0;
      op_error       <= 1'b0;
    end else begin
      // Register file accepts writes only while idle
      if (w_wr && !busy) begin
        case (w_sel)
          ADDR_CTRL:  r_ctrl     <= PWDATA;
          ADDR_DATA:  r_data_in  <= PWDATA;
          ADDR_WIDTH: r_cw_width <= PWDATA;
          ADDR_NOISE: r_noise    <= PWDATA;
        endcase
      end

      case (r_state)
        ST_IDLE: begin
          if (w_wr && w_sel == ADDR_CTRL) begin
            // Command outputs are loaded on entry so they are valid throughout LOAD
            r_state    <= ST_LOAD;
            busy       <= 1'b1;
            op_error   <= 1'b0;
            r_cnt      <= '0;
            dp_start   <= (PWDATA[1:0] != MODE_ILLEGAL);
            dp_mode    <= PWDATA[1:0];
            dp_width   <= r_cw_width[1:0];
            dp_data_in <= DATA_WIDTH'(r_data_in);
            dp_noise   <= DATA_WIDTH'(r_noise);
          end
        end
        ST_LOAD: begin
          dp_start <= 1'b0;
          r_cnt    <= '0;
          if (dp_mode == MODE_ILLEGAL) begin
            r_state        <= ST_DONE;
            operation_done <= 1'b1;
            op_error       <= 1'b1;
            data_out       <= '0;
            num_of_errors  <= 2'b00;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // dp_done wins over a coincident timeout
          if (dp_done) begin
            r_state        <= ST_DONE;
            operation_done <= 1'b1;
            op_error       <= 1'b0;
            data_out       <= dp_data_out;
            num_of_errors  <= (dp_mode == MODE_ENC) ? 2'b00 : dp_nof;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state        <= ST_DONE;
            operation_done <= 1'b1;
            op_error       <= 1'b1;
            data_out       <= '0;
            num_of_errors  <= 2'b00;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state        <= ST_IDLE;
          operation_done <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encdec_sequencer.sv
// Directed bench for encdec_sequencer: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on every operation_done pulse.
module tb_encdec_sequencer;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        dp_start;
  logic [1:0]  dp_mode, dp_width;
  logic [31:0] dp_data_in, dp_noise;
  logic        dp_done;
  logic [31:0] dp_data_out;
  logic [1:0]  dp_nof;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        operation_done, busy, op_error;

  encdec_sequencer #(
    .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dp_start(dp_start), .dp_mode(dp_mode), .dp_width(dp_width),
    .dp_data_in(dp_data_in), .dp_noise(dp_noise),
    .dp_done(dp_done), .dp_data_out(dp_data_out), .dp_nof(dp_nof),
    .data_out(data_out), .num_of_errors(num_of_errors),
    .operation_done(operation_done), .busy(busy), .op_error(op_error)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] A_CTRL  = 20'h0;
  localparam logic [19:0] A_DATA  = 20'h4;
  localparam logic [19:0] A_WIDTH = 20'h8;
  localparam logic [19:0] A_NOISE = 20'hC;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  nerr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && operation_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_operation_done", 32'd1, 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        check("data_out", data_out, m_exp.data);
        check("num_of_errors", 32'(num_of_errors), 32'(m_exp.nerr));
        check("op_error", 32'(op_error), 32'(m_exp.err));
      end
    end
  end

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (operation_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("operation_done_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_dp_done(input logic [31:0] data, input logic [1:0] nof);
    dp_done = 1'b1; dp_data_out = data; dp_nof = nof;
    @(negedge clk);
    dp_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        err;
    logic [31:0] rd;
    int          n;

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; dp_done = 1'b0; dp_data_out = '0; dp_nof = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp_start", 32'(dp_start), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_done_err", 32'({operation_done, op_error, num_of_errors}), 32'd0);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_prdata", PRDATA, 32'd0);
    rst = 1'b0;

    // Encode: nof from datapath must be masked to 00
    apb_write(A_DATA, 32'h0000_00A5, err);
    apb_write(A_WIDTH, 32'h0, err);
    exp_q.push_back('{data: 32'h5A, nerr: 2'b00, err: 1'b0});
    apb_write(A_CTRL, 32'h0, err);
    check("ctrl_write_pslverr", 32'(err), 32'd0);
    check("enc_dp_start", 32'(dp_start), 32'd1);
    check("enc_dp_data_in", dp_data_in, 32'hA5);
    check("enc_dp_mode", 32'(dp_mode), 32'd0);
    check("enc_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("enc_dp_start_one_cycle", 32'(dp_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    pulse_dp_done(32'h5A, 2'b11);
    wait_done(n);
    @(negedge clk);
    check("enc_idle_busy", 32'(busy), 32'd0);
    pulse_dp_done(32'hFFFF_FFFF, 2'b01);
    @(negedge clk);
    check("idle_dp_done_ignored", data_out, 32'h5A);

    // Decode with noise, success on first WAIT cycle
    apb_write(A_NOISE, 32'h3, err);
    exp_q.push_back('{data: 32'h1234_5678, nerr: 2'b10, err: 1'b0});
    apb_write(A_CTRL, 32'h1, err);
    check("dec_dp_noise", dp_noise, 32'h3);
    check("dec_dp_mode", 32'(dp_mode), 32'd1);
    @(negedge clk);
    pulse_dp_done(32'h1234_5678, 2'b10);
    wait_done(n);
    @(negedge clk);

    // Timeout with width 11 passed through
    apb_write(A_WIDTH, 32'h3, err);
    exp_q.push_back('{data: 32'h0, nerr: 2'b00, err: 1'b1});
    apb_write(A_CTRL, 32'h2, err);
    check("to_dp_width", 32'(dp_width), 32'd3);
    wait_done(n);
    check("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
    @(negedge clk);

    // Write while busy is rejected, read while busy is legal
    exp_q.push_back('{data: 32'h0000_CAFE, nerr: 2'b01, err: 1'b0});
    apb_write(A_CTRL, 32'h1, err);
    check("load_clears_op_error", 32'(op_error), 32'd0);
    apb_write(A_DATA, 32'h1234, err);
    check("busy_write_pslverr", 32'(err), 32'd1);
    apb_read(A_DATA, rd);
    check("busy_write_ignored", rd, 32'hA5);
    pulse_dp_done(32'h0000_CAFE, 2'b01);
    wait_done(n);
    @(negedge clk);

    // Illegal mode: no dp_start, straight to DONE
    exp_q.push_back('{data: 32'h0, nerr: 2'b00, err: 1'b1});
    apb_write(A_CTRL, 32'h3, err);
    check("illegal_dp_start", 32'(dp_start), 32'd0);
    check("illegal_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("illegal_latency", 32'(n), 32'd1);
    @(negedge clk);

    // dp_done in the timeout cycle counts as success
    exp_q.push_back('{data: 32'h0000_BEEF, nerr: 2'b01, err: 1'b0});
    apb_write(A_CTRL, 32'h2, err);
    repeat (TIMEOUT) @(negedge clk);
    pulse_dp_done(32'h0000_BEEF, 2'b01);
    wait_done(n);
    check("coincident_latency", 32'(n), 32'd0);
    @(negedge clk);

    // Reset during WAIT abandons the operation
    apb_write(A_CTRL, 32'h1, err);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dp_start_mode", 32'({dp_start, dp_mode}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apb_read(A_CTRL, rd);
    check("midrst_ctrl", rd, 32'd0);
    apb_read(A_DATA, rd);
    check("midrst_data_in", rd, 32'd0);
    apb_read(A_WIDTH, rd);
    check("midrst_width", rd, 32'd0);
    apb_read(A_NOISE, rd);
    check("midrst_noise", rd, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    pulse_dp_done(32'h5555_5555, 2'b10);
    repeat (TIMEOUT + 4) @(negedge clk);
    check("midrst_still_idle", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
